// File: rtl/fft_agu_sequencer_pkg.sv
// Shared AGU mode codes, sequencer state encoding and default transform size
// for the FFT address-generator phase controller.
package fft_agu_sequencer_pkg;

  localparam int AGU_MODE_WIDTH = 2;

  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_OP_RAM  = 2'd0;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_ROM_RAM = 2'd1;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_BF_RAM  = 2'd2;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_RAM_OP  = 2'd3;

  localparam int DEF_N_POINTS = 128;
  localparam int DEF_LOG_N    = 7;

  typedef enum logic [2:0] {
    SEQ_ST_IDLE,
    SEQ_ST_ROM_COPY,
    SEQ_ST_LOAD,
    SEQ_ST_BF,
    SEQ_ST_BF_DRAIN,
    SEQ_ST_UNLOAD,
    SEQ_ST_DONE
  } seqState_t;

  // Phases that open with an AGU reinit cycle before the counted run.
  function automatic logic hasSetup(input seqState_t s);
    return (s == SEQ_ST_ROM_COPY) || (s == SEQ_ST_LOAD) ||
           (s == SEQ_ST_BF) || (s == SEQ_ST_UNLOAD);
  endfunction

endpackage

// File: rtl/fft_phase_counter.sv
// Phase counter: load clears the count and latches the terminal value; otherwise
// counts up every cycle, tc flags count == terminal.
module fft_phase_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] pc,
  output logic             tc
);

  logic [CNT_W-1:0] termVal;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      termVal <= '0;
    end else if (load) begin
      pc      <= '0;
      termVal <= limit;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  assign tc = (pc == termVal);

endmodule

// File: rtl/fft_agu_sequencer.sv
// FFT phase controller: ROM copy, bit-reversed load, LOG_N butterfly stages, drain, unload.
// Optional build macro FFT_SEQ_IFFT_EN: latched inverse-transform select plus one flush cycle in UNLOAD.
//
// state     | meaning
// IDLE      | waiting for start, AGU held in reinit
// ROM_COPY  | twiddle ROM -> RAM copy
// LOAD      | operand input -> RAM (bit-reversed by AGU)
// BF        | LOG_N butterfly stages, writes follow delayed AGU strobe
// BF_DRAIN  | pipeline flush until last butterfly write lands
// UNLOAD    | RAM -> operand output
// DONE      | one-cycle completion pulse
module fft_agu_sequencer
  import fft_agu_sequencer_pkg::*;
#(
  parameter int N_POINTS     = DEF_N_POINTS,
  parameter int LOG_N        = DEF_LOG_N,
  parameter int TWID_WORDS   = 128,
  parameter int BF_DRAIN_CYC = 8,
  parameter int CNT_W        = 12,
  parameter int STAGE_W      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      ifft_req,
  input  logic                      agu_we_ram,
  output logic [AGU_MODE_WIDTH-1:0] agu_mode,
  output logic                      agu_reset,
  output logic                      agu_start,
  output logic                      agu_output_en,
  output logic                      agu_ifft,
  output logic                      ram_we,
  output logic [STAGE_W-1:0]        stage_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int BF_SPAN = 4 * N_POINTS;
  localparam int PC_LOW  = $clog2(BF_SPAN);
`ifdef FFT_SEQ_IFFT_EN
  localparam int UNLOAD_EXTRA = 1;
`else
  localparam int UNLOAD_EXTRA = 0;
`endif

  localparam logic [CNT_W-1:0]   ROM_LEN    = CNT_W'(TWID_WORDS);
  localparam logic [CNT_W-1:0]   LOAD_LEN   = CNT_W'(2 * N_POINTS);
  localparam logic [CNT_W-1:0]   BF_LEN     = CNT_W'(LOG_N * BF_SPAN);
  localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(BF_DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]   UNLOAD_LEN = CNT_W'(2 * N_POINTS + UNLOAD_EXTRA);
  localparam logic [STAGE_W-1:0] STAGE_MAX  = STAGE_W'(LOG_N - 1);

  if (LOG_N * BF_SPAN >= (1 << CNT_W)) begin : g_cntTooNarrow
    $error("CNT_W cannot hold LOG_N*4*N_POINTS");
  end

  seqState_t        state, nextState;
  logic             setupPhase, setupNext;
  logic             weDly;
  logic [STAGE_W-1:0] stageIdx;
  logic             pcLoad, pcTc;
  logic [CNT_W-1:0] pcLimit, pc;

  fft_phase_counter #(.CNT_W(CNT_W)) u_phaseCounter (
    .clk   (clk),
    .reset (reset),
    .load  (pcLoad),
    .limit (pcLimit),
    .pc    (pc),
    .tc    (pcTc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEQ_ST_IDLE;
      setupPhase <= 1'b0;
      weDly      <= 1'b0;
      stageIdx   <= '0;
    end else begin
      state      <= nextState;
      setupPhase <= setupNext;
      weDly      <= agu_we_ram;
      if (state == SEQ_ST_BF) begin
        if (setupPhase)
          stageIdx <= '0;
        else if ((&pc[PC_LOW-1:0]) && (stageIdx != STAGE_MAX))
          stageIdx <= stageIdx + 1'b1;
      end
    end
  end

  always_comb begin
    nextState     = state;
    pcLoad        = 1'b0;
    pcLimit       = '0;
    agu_mode      = AGU_MODE_ROM_RAM;
    agu_reset     = 1'b0;
    agu_start     = 1'b0;
    agu_output_en = 1'b0;
    ram_we        = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      SEQ_ST_IDLE: begin
        agu_reset = 1'b1;
        busy      = 1'b0;
        pcLoad    = 1'b1;
        if (start) nextState = SEQ_ST_ROM_COPY;
      end
      SEQ_ST_ROM_COPY, SEQ_ST_LOAD: begin
        agu_mode      = (state == SEQ_ST_LOAD) ? AGU_MODE_OP_RAM : AGU_MODE_ROM_RAM;
        agu_output_en = 1'b1;
        if (setupPhase) begin
          agu_reset = 1'b1;
          pcLoad    = 1'b1;
          pcLimit   = (state == SEQ_ST_LOAD) ? LOAD_LEN : ROM_LEN;
        end else begin
          agu_start = (pc == '0);
          ram_we    = (pc != '0);
          if (pcTc) nextState = (state == SEQ_ST_LOAD) ? SEQ_ST_BF : SEQ_ST_LOAD;
        end
      end
      SEQ_ST_BF: begin
        agu_mode      = AGU_MODE_BF_RAM;
        agu_output_en = 1'b1;
        ram_we        = weDly;
        if (setupPhase) begin
          agu_reset = 1'b1;
          pcLoad    = 1'b1;
          pcLimit   = BF_LEN;
        end else begin
          agu_start = (pc == '0);
          if (pcTc) begin
            // Drain has no setup cycle, so its count is armed here.
            nextState = SEQ_ST_BF_DRAIN;
            pcLoad    = 1'b1;
            pcLimit   = DRAIN_LAST;
          end
        end
      end
      SEQ_ST_BF_DRAIN: begin
        agu_mode      = AGU_MODE_BF_RAM;
        agu_output_en = 1'b1;
        ram_we        = weDly;
        if (pcTc) nextState = SEQ_ST_UNLOAD;
      end
      SEQ_ST_UNLOAD: begin
        agu_mode = AGU_MODE_RAM_OP;
        if (setupPhase) begin
          agu_reset = 1'b1;
          pcLoad    = 1'b1;
          pcLimit   = UNLOAD_LEN;
        end else begin
          agu_start = (pc == '0);
          if (pcTc) nextState = SEQ_ST_DONE;
        end
      end
      SEQ_ST_DONE: begin
        agu_mode  = AGU_MODE_RAM_OP;
        busy      = 1'b0;
        done      = 1'b1;
        nextState = SEQ_ST_IDLE;
      end
      default: nextState = SEQ_ST_IDLE;
    endcase
    setupNext = (nextState != state) && hasSetup(nextState);
  end

  assign stage_idx = stageIdx;

`ifdef FFT_SEQ_IFFT_EN
  logic ifftLat;

  always_ff @(posedge clk) begin
    if (reset)
      ifftLat <= 1'b0;
    else if ((state == SEQ_ST_IDLE) && start)
      ifftLat <= ifft_req;
    else if (state == SEQ_ST_DONE)
      ifftLat <= 1'b0;
  end

  assign agu_ifft = ifftLat;
`else
  logic unusedIfftReq;
  assign unusedIfftReq = ifft_req;
  assign agu_ifft      = 1'b0;
`endif

endmodule

// File: tb/tb_fft_agu_sequencer.sv
// Bench for fft_agu_sequencer: phase-schedule model checked every cycle plus
// hand-computed timing pins for full runs, ignored starts, mid-BF reset and back-to-back runs.
module tb_fft_agu_sequencer;
  import fft_agu_sequencer_pkg::*;

  localparam int N    = 128;
  localparam int LOGN = 7;
  localparam int TW   = 128;
  localparam int DR   = 8;
`ifdef FFT_SEQ_IFFT_EN
  localparam int IFX = 1;
`else
  localparam int IFX = 0;
`endif
  // Position (cycles after the accepted start) where each phase begins.
  localparam int B_LD = 1 + TW + 2;
  localparam int B_BF = B_LD + 2 * N + 2;
  localparam int B_DR = B_BF + LOGN * 4 * N + 2;
  localparam int B_UN = B_DR + DR;
  localparam int B_DN = B_UN + 2 * N + IFX + 2;
  localparam int DONE_REL = 4241 + IFX;

  logic clk, reset, start, ifft_req, agu_we_ram;
  logic [1:0] agu_mode;
  logic agu_reset, agu_start, agu_output_en, agu_ifft, ram_we, busy, done;
  logic [2:0] stage_idx;

  fft_agu_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ifft_req      (ifft_req),
    .agu_we_ram    (agu_we_ram),
    .agu_mode      (agu_mode),
    .agu_reset     (agu_reset),
    .agu_start     (agu_start),
    .agu_output_en (agu_output_en),
    .agu_ifft      (agu_ifft),
    .ram_we        (ram_we),
    .stage_idx     (stage_idx),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;
  bit checkEn = 1'b0;
  int cycNum = 0;

  bit mAct = 1'b0;
  int mP = 0;
  bit mPw = 1'b0;
  bit mIfft = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    totalCnt++;
    if (act === req) passCnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs from the phase schedule: {mode, rst, start, oe, we, busy, done, ifft, stage}.
  task automatic model_out(input bit act, input int p, input bit pw, input bit ifl,
                           output logic [11:0] e, output logic [11:0] msk);
    int k;
    int s;
    e   = {AGU_MODE_ROM_RAM, 1'b1, 9'b0};
    msk = 12'hFF8;
    if (act) begin
      e[9] = 1'b0;
      e[5] = 1'b1;
      e[3] = (IFX == 1) && ifl;
      if (p < B_LD) begin
        k = p - 1;
        e[11:10] = AGU_MODE_ROM_RAM;
        e[7] = 1'b1; e[9] = (k == 0); e[8] = (k == 1); e[6] = (k >= 2);
      end else if (p < B_BF) begin
        k = p - B_LD;
        e[11:10] = AGU_MODE_OP_RAM;
        e[7] = 1'b1; e[9] = (k == 0); e[8] = (k == 1); e[6] = (k >= 2);
      end else if (p < B_DR) begin
        k = p - B_BF;
        e[11:10] = AGU_MODE_BF_RAM;
        e[7] = 1'b1; e[9] = (k == 0); e[8] = (k == 1); e[6] = pw;
        if (k >= 1) begin
          s = (k - 1) / (4 * N);
          if (s > LOGN - 1) s = LOGN - 1;
          e[2:0] = 3'(s);
          msk[2:0] = 3'b111;
        end
      end else if (p < B_UN) begin
        e[11:10] = AGU_MODE_BF_RAM;
        e[7] = 1'b1; e[6] = pw;
        e[2:0] = 3'(LOGN - 1);
        msk[2:0] = 3'b111;
      end else if (p < B_DN) begin
        k = p - B_UN;
        e[11:10] = AGU_MODE_RAM_OP;
        e[9] = (k == 0); e[8] = (k == 1);
      end else begin
        e[11:10] = AGU_MODE_RAM_OP;
        e[5] = 1'b0; e[4] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e, msk, a;
    cycNum++;
    if (checkEn) begin
      model_out(mAct, mP, mPw, mIfft, e, msk);
      a = {agu_mode, agu_reset, agu_start, agu_output_en, ram_we, busy, done, agu_ifft, stage_idx};
      totalCnt++;
      if ((a & msk) === (e & msk)) passCnt++;
      else $display("FAIL outputs cyc%0d pos%0d: got %h, expected %h (mask %h)",
                    cycNum, mAct ? mP : -1, a & msk, e & msk, msk);
      if (reset) begin
        mAct = 1'b0;
        mPw  = 1'b0;
      end else begin
        mPw = agu_we_ram;
        if (mAct) begin
          if (mP == B_DN) mAct = 1'b0;
          else mP++;
        end else if (start) begin
          mAct  = 1'b1;
          mP    = 1;
          mIfft = ifft_req;
        end
      end
    end
  end

  initial begin
    agu_we_ram = 1'b0;
    forever begin
      tick();
      agu_we_ram = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int rel, romWe, ldWe, unWe, firstStart, st1, st3, st6, doneRel, target, d1, d2;
    bit sawDone;
    reset = 1'b1; start = 1'b0; ifft_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b1;
    chk("reset_agu_reset", agu_reset, 1);
    chk("reset_agu_mode", agu_mode, AGU_MODE_ROM_RAM);
    chk("reset_busy", busy, 0);
    chk("reset_ram_we", ram_we, 0);
    chk("reset_agu_start", agu_start, 0);
    chk("reset_output_en", agu_output_en, 0);
    chk("reset_stage", stage_idx, 0);
    chk("reset_done", done, 0);
    chk("reset_ifft", agu_ifft, 0);
    tick(); reset = 1'b0;
    repeat (3) tick();

    // Full run with ignored starts at 5, 1000 and in the DONE cycle.
    ifft_req = 1'b1; start = 1'b1;
    rel = 0; romWe = 0; ldWe = 0; unWe = 0;
    firstStart = -1; st1 = -1; st3 = -1; st6 = -1; doneRel = -1;
    while (doneRel < 0 && rel < 6000) begin
      tick(); rel++;
      start = (rel == 5) || (rel == 1000);
      ifft_req = 1'($urandom_range(0, 1));
      if (busy && ram_we && agu_mode == AGU_MODE_ROM_RAM) romWe++;
      if (busy && ram_we && agu_mode == AGU_MODE_OP_RAM) ldWe++;
      if (busy && ram_we && agu_mode == AGU_MODE_RAM_OP) unWe++;
      if (agu_start && firstStart < 0) firstStart = rel;
      if (stage_idx == 3'd1 && st1 < 0) st1 = rel;
      if (stage_idx == 3'd3 && st3 < 0) st3 = rel;
      if (stage_idx == 3'd6 && st6 < 0) st6 = rel;
      if (done) begin
        doneRel = rel;
        start = 1'b1;
      end
    end
    chk("run1_first_agu_start", firstStart, 2);
    chk("run1_rom_writes", romWe, 128);
    chk("run1_load_writes", ldWe, 256);
    chk("run1_unload_writes", unWe, 0);
    chk("run1_stage1_cycle", st1, 902);
    chk("run1_stage3_cycle", st3, 1926);
    chk("run1_stage6_cycle", st6, 3462);
    chk("run1_done_cycle", doneRel, DONE_REL);
    tick(); start = 1'b0;
    chk("after_done_busy", busy, 0);
    chk("after_done_agu_reset", agu_reset, 1);
    tick();
    chk("done_start_ignored", busy, 0);
    repeat (5) tick();

    // Reset in the middle of butterfly stage 3.
    ifft_req = 1'($urandom_range(0, 1)); start = 1'b1;
    rel = 0;
    target = 1926 + int'($urandom_range(0, 400));
    while (rel < target) begin
      tick(); rel++;
      start = 1'b0;
    end
    chk("midbf_stage_before_reset", stage_idx, 3);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("midbf_reset_busy", busy, 0);
    chk("midbf_reset_ram_we", ram_we, 0);
    chk("midbf_reset_agu_reset", agu_reset, 1);
    sawDone = 1'b0;
    repeat (40) begin
      tick();
      sawDone |= done;
    end
    chk("midbf_no_done", sawDone, 0);

    // Run after reset, then a back-to-back start in the first IDLE cycle.
    start = 1'b1; rel = 0; d1 = -1;
    while (d1 < 0 && rel < 6000) begin
      tick(); rel++;
      start = 1'b0;
      if (done) d1 = rel;
    end
    chk("run3_done_cycle", d1, DONE_REL);
    tick();
    start = 1'b1; rel = 0; d2 = -1;
    while (d2 < 0 && rel < 6000) begin
      tick(); rel++;
      start = 1'b0;
      if (done) d2 = rel;
    end
    chk("backtoback_done_cycle", d2, DONE_REL);
    repeat (5) tick();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
